// File: rtl/usrt_pkg.sv
// Shared USRT link definitions: FSM state encodings and frame geometry.
// State encodings are common to the tx and rx shift registers.
package usrt_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } usrt_state_e;

endpackage

// File: rtl/usrt_sync.sv
// Multi-flop synchroniser with a registered level and a one-cycle falling-edge pulse.
// Level and pulse both appear STAGES+1 cycles after the input changes, so two instances stay aligned.
module usrt_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic fall_o
);

  logic [STAGES-1:0] stg_q;
  logic              prev_q;
  logic              fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_q  <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      fall_q <= 1'b0;
    end else begin
      stg_q  <= {stg_q[STAGES-2:0], d_i};
      prev_q <= stg_q[STAGES-1];
      fall_q <= prev_q & ~stg_q[STAGES-1];
    end
  end

  assign lvl_o  = prev_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/rxshift.sv
// USRT receive shift register: samples the line on each synchronised i_Bclk fall, single i_Pclk domain.
// Byte commits SYNC_STAGES+2 cycles after the stop-bit fall; no backpressure, an unread byte is overwritten and flagged.
module rxshift #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = usrt_pkg::DATA_BITS
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst_n,
  input  logic                 i_Bclk,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Read,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Data_Valid,
  output logic                 o_Pready,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);

  import usrt_pkg::*;

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic sample;
  logic rx;
  logic bclk_lvl_unused;
  logic rx_fall_unused;

  usrt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_bclk (
    .clk_i  (i_Pclk),
    .rst_ni (i_Rst_n),
    .d_i    (i_Bclk),
    .lvl_o  (bclk_lvl_unused),
    .fall_o (sample)
  );

  usrt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rx (
    .clk_i  (i_Pclk),
    .rst_ni (i_Rst_n),
    .d_i    (i_Rx_Serial),
    .lvl_o  (rx),
    .fall_o (rx_fall_unused)
  );

  usrt_state_e          state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pready_q, pready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 commit;

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pready_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      pready_q <= pready_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample && !rx) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d[idx_q] = rx;
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_STOP: begin
        if (sample) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A read in the commit cycle consumes the old byte, so it suppresses overrun.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    pready_d = i_Read;
    if (i_Read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~rx;
      if (valid_q && !i_Read) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_Data       = data_q;
  assign o_Data_Valid = valid_q;
  assign o_Pready     = pready_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Overrun    = ovr_q;

endmodule

// File: tb/tb_rxshift.sv
// Self-checking bench for rxshift: directed scenarios plus randomized frames against a byte-level model.
module tb_rxshift;

  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic       i_Pclk;
  logic       i_Rst_n;
  logic       i_Bclk;
  logic       i_Rx_Serial;
  logic       i_Read;
  logic [7:0] o_Data;
  logic       o_Data_Valid;
  logic       o_Pready;
  logic       o_Frame_Err;
  logic       o_Overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  rxshift #(.SYNC_STAGES(SYNC), .DATA_BITS(8)) dut (
    .i_Pclk       (i_Pclk),
    .i_Rst_n      (i_Rst_n),
    .i_Bclk       (i_Bclk),
    .i_Rx_Serial  (i_Rx_Serial),
    .i_Read       (i_Read),
    .o_Data       (o_Data),
    .o_Data_Valid (o_Data_Valid),
    .o_Pready     (o_Pready),
    .o_Frame_Err  (o_Frame_Err),
    .o_Overrun    (o_Overrun)
  );

  initial i_Pclk = 1'b0;
  always #5 i_Pclk = ~i_Pclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // One bit cell: line changes with Bclk rise, Bclk falls mid-bit.
  task automatic drive_bit(input logic b, input bit is_stop, input bit rd,
                           output int lat, output logic pr);
    lat = -1;
    pr  = 1'b0;
    @(negedge i_Pclk);
    i_Bclk = 1'b1;
    i_Rx_Serial = b;
    repeat (HALF - 1) @(negedge i_Pclk);
    @(negedge i_Pclk);
    i_Bclk = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge i_Pclk);
      #1;
      if (is_stop && lat < 0 && o_Data_Valid) lat = k;
      if (is_stop && rd && k == SYNC + 1) i_Read = 1'b1;
      if (is_stop && rd && k == SYNC + 2) begin
        pr = o_Pready;
        i_Read = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd,
                            output int lat, output logic pr);
    int   l;
    logic p;
    drive_bit(1'b0, 1'b0, 1'b0, l, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0, 1'b0, l, p);
    drive_bit(stop, 1'b1, rd, lat, pr);
    drive_bit(1'b1, 1'b0, 1'b0, l, p);
    if (rd) begin
      m_ovr = 1'b0;
    end else if (m_valid) begin
      m_ovr = 1'b1;
    end
    m_valid = 1'b1;
    m_data  = d;
    m_ferr  = ~stop;
  endtask

  task automatic do_read(output logic p1, output logic p0);
    @(negedge i_Pclk);
    i_Read = 1'b1;
    @(negedge i_Pclk);
    i_Read = 1'b0;
    p1 = o_Pready;
    @(negedge i_Pclk);
    p0 = o_Pready;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0; i_Bclk = 1'b0; i_Rx_Serial = 1'b1; i_Read = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Pclk);
    i_Rst_n = 1'b1;
    repeat (4) @(negedge i_Pclk);
    checks++; if (o_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_Data); end
    checks++; if (o_Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_Data_Valid); end
    checks++; if (o_Pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", o_Pready); end
    checks++; if (o_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_Frame_Err); end
    checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", o_Overrun); end
  endtask

  task automatic test_basic_frame();
    int lat; logic pr;
    repeat (2) drive_bit(1'b1, 1'b0, 1'b0, lat, pr);
    send_frame(8'hA5, 1'b1, 1'b0, lat, pr);
    checks++; if (lat !== SYNC + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, SYNC + 2); end
    checks++; if (o_Data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", o_Data); end
    checks++; if (o_Data_Valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", o_Data_Valid); end
    checks++; if (o_Frame_Err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", o_Frame_Err); end
    checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b want 0", o_Overrun); end
  endtask

  task automatic test_read();
    logic p1, p0, p2;
    do_read(p1, p0);
    checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL read_ack: got %b want 1", p1); end
    checks++; if (p0 !== 1'b0) begin errors++; $display("FAIL read_ack_once: got %b want 0", p0); end
    checks++; if (o_Data_Valid !== 1'b0) begin errors++; $display("FAIL read_valid: got %b want 0", o_Data_Valid); end
    checks++; if (o_Data !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", o_Data); end
    do_read(p2, p0);
    checks++; if (p2 !== 1'b1) begin errors++; $display("FAIL read_empty_ack: got %b want 1", p2); end
    checks++; if (o_Data !== 8'hA5) begin errors++; $display("FAIL read_empty_data: got %h want a5", o_Data); end
  endtask

  task automatic test_frame_err();
    int lat; logic pr, p1, p0;
    send_frame(8'h3C, 1'b0, 1'b0, lat, pr);
    checks++; if (o_Data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", o_Data); end
    checks++; if (o_Data_Valid !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b want 1", o_Data_Valid); end
    checks++; if (o_Frame_Err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", o_Frame_Err); end
    do_read(p1, p0);
    checks++; if (o_Frame_Err !== 1'b1) begin errors++; $display("FAIL ferr_hold: got %b want 1", o_Frame_Err); end
    send_frame(8'h01, 1'b1, 1'b0, lat, pr);
    checks++; if (o_Frame_Err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", o_Frame_Err); end
    checks++; if (o_Data !== 8'h01) begin errors++; $display("FAIL ferr_next_data: got %h want 01", o_Data); end
    do_read(p1, p0);
  endtask

  task automatic test_overrun();
    int lat; logic pr, p1, p0;
    send_frame(8'h11, 1'b1, 1'b0, lat, pr);
    send_frame(8'h22, 1'b1, 1'b0, lat, pr);
    checks++; if (o_Data !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h want 22", o_Data); end
    checks++; if (o_Overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", o_Overrun); end
    do_read(p1, p0);
    checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", o_Overrun); end
    checks++; if (o_Data_Valid !== 1'b0) begin errors++; $display("FAIL ovr_read_valid: got %b want 0", o_Data_Valid); end
  endtask

  task automatic test_read_at_commit();
    int lat; logic pr, p1, p0;
    send_frame(8'h11, 1'b1, 1'b0, lat, pr);
    send_frame(8'h7E, 1'b1, 1'b1, lat, pr);
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL rdc_ack: got %b want 1", pr); end
    checks++; if (o_Data !== 8'h7E) begin errors++; $display("FAIL rdc_data: got %h want 7e", o_Data); end
    checks++; if (o_Data_Valid !== 1'b1) begin errors++; $display("FAIL rdc_valid: got %b want 1", o_Data_Valid); end
    checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL rdc_ovr: got %b want 0", o_Overrun); end
    do_read(p1, p0);
  endtask

  task automatic test_reset_mid_frame();
    int lat; logic pr;
    drive_bit(1'b0, 1'b0, 1'b0, lat, pr);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0, lat, pr);
    @(negedge i_Pclk);
    i_Rst_n = 1'b0;
    i_Rx_Serial = 1'b1;
    model_reset();
    repeat (3) @(negedge i_Pclk);
    i_Rst_n = 1'b1;
    repeat (2) drive_bit(1'b1, 1'b0, 1'b0, lat, pr);
    checks++; if (o_Data_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_Data_Valid); end
    checks++; if (o_Data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", o_Data); end
    send_frame(8'h81, 1'b1, 1'b0, lat, pr);
    checks++; if (o_Data !== 8'h81) begin errors++; $display("FAIL rstmid_new_data: got %h want 81", o_Data); end
    checks++; if (o_Frame_Err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b want 0", o_Frame_Err); end
    checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL rstmid_ovr: got %b want 0", o_Overrun); end
  endtask

  task automatic test_random();
    int lat; logic pr, p1, p0;
    logic [7:0] d;
    logic stop;
    bit rd;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      rd   = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, rd, lat, pr);
      if (rd) begin
        checks++; if (pr !== 1'b1) begin errors++; $display("FAIL rnd_ack[%0d]: got %b want 1", n, pr); end
      end
      checks++; if (o_Data !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, o_Data, m_data); end
      checks++; if (o_Data_Valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, o_Data_Valid, m_valid); end
      checks++; if (o_Frame_Err !== m_ferr) begin errors++; $display("FAIL rnd_ferr[%0d]: got %b want %b", n, o_Frame_Err, m_ferr); end
      checks++; if (o_Overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d]: got %b want %b", n, o_Overrun, m_ovr); end
      if ($urandom_range(0, 1) == 1) begin
        do_read(p1, p0);
        checks++; if (p1 !== 1'b1 || p0 !== 1'b0) begin errors++; $display("FAIL rnd_read_ack[%0d]: got %b%b want 10", n, p1, p0); end
        checks++; if (o_Data_Valid !== m_valid || o_Overrun !== m_ovr) begin
          errors++; $display("FAIL rnd_read_clear[%0d]: got v=%b o=%b want v=%b o=%b", n, o_Data_Valid, o_Overrun, m_valid, m_ovr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_read();
    test_frame_err();
    test_overrun();
    test_read_at_commit();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
